// File: rtl/serial_pattern_tx_if.sv
// rtl/serial_pattern_tx_if.sv - request/serial-output bundle for the pattern transmitter
interface serial_pattern_tx_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4,
  parameter int GAP_W = 4
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [REP_W-1:0] reps;
  logic [GAP_W-1:0] gap;
  logic             abort;
  logic             P1;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, len, reps, gap, abort,
    input  P1, valid, busy, done
  );

  modport slave (
    input  start, pattern, len, reps, gap, abort,
    output P1, valid, busy, done
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - MSB-first serial pattern transmitter with repeats, gaps and abort
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4,
  parameter int GAP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  serial_pattern_tx_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic             p1_q, p1_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fin;
  logic [LEN_W-1:0] len_clamp;
  logic [WIDTH-1:0] src;

  assign len_clamp = (bus.len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : bus.len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      p1_q    <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      p1_q    <= p1_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // rep_q counts repetitions still to go after the current one, so it never decrements past zero.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    fin     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && (bus.len != '0)) begin
          state_d = S_SHIFT;
          pat_d   = bus.pattern;
          len_d   = len_clamp;
          idx_d   = len_clamp - 1'b1;
          rep_d   = (bus.reps == '0) ? '0 : bus.reps - 1'b1;
          gap_d   = bus.gap;
        end
      end
      S_SHIFT: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (idx_q != '0) begin
          idx_d = idx_q - 1'b1;
        end else if (rep_q != '0) begin
          rep_d = rep_q - 1'b1;
          if (gap_q != '0) begin
            state_d = S_GAP;
            gcnt_d  = gap_q - 1'b1;
          end else begin
            idx_d = len_q - 1'b1;
          end
        end else begin
          state_d = S_IDLE;
          fin     = 1'b1;
        end
      end
      S_GAP: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (gcnt_q != '0) begin
          gcnt_d = gcnt_q - 1'b1;
        end else begin
          state_d = S_SHIFT;
          idx_d   = len_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are derived from the next state so they appear registered on the same edge.
  always_comb begin
    src     = (state_q == S_IDLE) ? bus.pattern : pat_q;
    valid_d = (state_d == S_SHIFT);
    busy_d  = (state_d != S_IDLE);
    done_d  = fin;
    p1_d    = valid_d & (|(src & (WIDTH'(1) << idx_d)));
  end

  assign bus.P1    = p1_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb/tb_serial_pattern_tx.sv - scoreboard bench for serial_pattern_tx
module tb_serial_pattern_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_pattern_tx_if #(.WIDTH(8), .LEN_W(4), .REP_W(4), .GAP_W(4)) bus ();

  serial_pattern_tx #(.WIDTH(8), .LEN_W(4), .REP_W(4), .GAP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] e;
  logic [3:0] obs;

  // Entries are {P1, valid, busy, done} observed after each edge.
  function automatic void push_exp(input logic [7:0] pat, input int len, input int reps,
                                   input int gap, input bit tail);
    int lc;
    int rc;
    lc = (len > 8) ? 8 : len;
    rc = (reps == 0) ? 1 : reps;
    for (int k = 0; k < rc; k++) begin
      for (int i = lc - 1; i >= 0; i--) exp_q.push_back({pat[i], 3'b110});
      if (k < rc - 1)
        for (int g = 0; g < gap; g++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
    if (tail) exp_q.push_back(4'b0000);
  endfunction

  task automatic set_req(input logic [7:0] pat, input logic [3:0] len, input logic [3:0] reps,
                         input logic [3:0] gap);
    bus.pattern = pat;
    bus.len     = len;
    bus.reps    = reps;
    bus.gap     = gap;
    bus.start   = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.abort = 1'b0;
    set_req(8'h05, 4'd3, 4'd1, 4'd0);
    repeat (2) begin
      @(negedge clk);
      obs = {bus.P1, bus.valid, bus.busy, bus.done};
      checks++;
      if (obs !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs got %b want 0000", obs);
      end
    end
    rst = 1'b0;
    push_exp(8'h05, 3, 1, 0, 1);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      bus.start = 1'b0;
      e = exp_q.pop_front();
      obs = {bus.P1, bus.valid, bus.busy, bus.done};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL after_reset_start got %b want %b", obs, e);
      end
    end
  endtask

  task automatic test_single();
    logic [2:0] seen;
    seen = 3'b000;
    set_req(8'b0000_0101, 4'd3, 4'd1, 4'd0);
    push_exp(8'b0000_0101, 3, 1, 0, 1);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      bus.start = 1'b0;
      e = exp_q.pop_front();
      obs = {bus.P1, bus.valid, bus.busy, bus.done};
      if (bus.valid === 1'b1) seen = {seen[1:0], bus.P1};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL single_rep got %b want %b", obs, e);
      end
    end
    checks++;
    if (seen !== 3'b101) begin
      errors++;
      $display("FAIL single_seq got %b want 101", seen);
    end
  endtask

  task automatic test_gap();
    int n;
    int busy_cycles;
    n = 0;
    busy_cycles = 0;
    set_req(8'b0000_0110, 4'd3, 4'd2, 4'd2);
    push_exp(8'b0000_0110, 3, 2, 2, 1);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      obs = {bus.P1, bus.valid, bus.busy, bus.done};
      if (bus.busy === 1'b1) busy_cycles++;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL rep_gap cycle %0d got %b want %b", n, obs, e);
      end
      if (n == 0) begin
        bus.start = 1'b0;
        set_req(8'hFF, 4'd1, 4'd9, 4'd7);
        bus.start = 1'b0;
      end
      n++;
    end
    checks++;
    if (busy_cycles != 8) begin
      errors++;
      $display("FAIL rep_gap_busy got %0d want 8", busy_cycles);
    end
  endtask

  task automatic test_clamp();
    set_req(8'hA5, 4'd0, 4'd1, 4'd0);
    repeat (3) exp_q.push_back(4'b0000);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      obs = {bus.P1, bus.valid, bus.busy, bus.done};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL len_zero got %b want %b", obs, e);
      end
    end
    set_req(8'hA5, 4'd15, 4'd1, 4'd0);
    push_exp(8'hA5, 15, 1, 0, 1);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      bus.start = 1'b0;
      e = exp_q.pop_front();
      obs = {bus.P1, bus.valid, bus.busy, bus.done};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL len_clamp got %b want %b", obs, e);
      end
    end
  endtask

  task automatic test_abort();
    int n;
    n = 0;
    set_req(8'b0000_1011, 4'd4, 4'd3, 4'd0);
    exp_q.push_back(4'b1110);
    exp_q.push_back(4'b0110);
    exp_q.push_back(4'b1110);
    exp_q.push_back(4'b1110);
    exp_q.push_back(4'b1110);
    repeat (4) exp_q.push_back(4'b0000);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      obs = {bus.P1, bus.valid, bus.busy, bus.done};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL abort cycle %0d got %b want %b", n, obs, e);
      end
      if (n == 1) bus.start = 1'b0;
      if (n == 4) bus.abort = 1'b1;
      if (n == 5) bus.abort = 1'b0;
      n++;
    end
  endtask

  task automatic test_back_to_back();
    int n;
    n = 0;
    set_req(8'h02, 4'd2, 4'd1, 4'd0);
    push_exp(8'h02, 2, 1, 0, 0);
    push_exp(8'h05, 3, 1, 0, 1);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      obs = {bus.P1, bus.valid, bus.busy, bus.done};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL back_to_back cycle %0d got %b want %b", n, obs, e);
      end
      if (n == 0) bus.start = 1'b0;
      if (n == 2) set_req(8'h05, 4'd3, 4'd1, 4'd0);
      if (n == 3) bus.start = 1'b0;
      n++;
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.pattern = '0;
    bus.len     = '0;
    bus.reps    = '0;
    bus.gap     = '0;
    test_reset();
    test_single();
    test_gap();
    test_clamp();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
